// File: rtl/map_matrix_scanner.sv
// -----------------------------------------------------------------------------
// map_matrix_scanner
//
// Column-multiplexed driver for the pixel-matrix display. A full active-low
// frame (column-major, bit c*COLUMN_SIZE+r = column c, row r, 0 = lit) is
// taken through a valid/ready handshake into a shadow buffer. It is copied to
// the active buffer only at a frame boundary, so a displayed scan never mixes
// two frames. While attack is high the displayed frame is frozen.
//
// Optional feature macro: MAP_BLINK_EN
//   Adds the BLINK_FRAMES parameter, the i_blink_mask port and a blink phase
//   that toggles every BLINK_FRAMES full scans. In the off phase, masked
//   pixels are forced unlit.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       1 = scan, 0 = blank outputs and hold counters at 0
//   i_frame_in     new frame, active-low pixels
//   i_frame_valid  i_frame_in valid
//   o_frame_ready  frame can be accepted (!pending && !attack)
//   i_attack       level, 1 = freeze displayed frame
//   i_blink_mask   1 = pixel blinks (MAP_BLINK_EN only)
//   o_column_sel   active-low one-hot column select (registered)
//   o_row_out      active-low row data of selected column (registered)
//   o_frame_done   one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module map_matrix_scanner #(
    parameter int COLUMN_SIZE   = 7,
    parameter int TOTAL_COLUMNS = 5,
    parameter int SCAN_DIV      = 1000,
`ifdef MAP_BLINK_EN
    parameter int BLINK_FRAMES  = 16,
`endif
    parameter int DATA_WIDTH    = COLUMN_SIZE * TOTAL_COLUMNS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [DATA_WIDTH-1:0]    i_frame_in,
    input  logic                     i_frame_valid,
    output logic                     o_frame_ready,
    input  logic                     i_attack,
`ifdef MAP_BLINK_EN
    input  logic [DATA_WIDTH-1:0]    i_blink_mask,
`endif
    output logic [TOTAL_COLUMNS-1:0] o_column_sel,
    output logic [COLUMN_SIZE-1:0]   o_row_out,
    output logic                     o_frame_done
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W = (TOTAL_COLUMNS > 1) ? $clog2(TOTAL_COLUMNS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLUMNS - 1);

    logic [DATA_WIDTH-1:0]    r_shadow;
    logic [DATA_WIDTH-1:0]    r_active;
    logic                     r_pending;
    logic [PRE_W-1:0]         r_prescaler;
    logic [COL_W-1:0]         r_col;
    logic [TOTAL_COLUMNS-1:0] r_column_sel;
    logic [COLUMN_SIZE-1:0]   r_row_out;
    logic                     r_frame_done;

    logic                     w_frame_ready;
    logic                     w_accept;
    logic                     w_pre_wrap;
    logic                     w_boundary;
    logic                     w_swap;
    logic [TOTAL_COLUMNS-1:0] w_col_onehot;
    logic [COLUMN_SIZE-1:0]   w_active_cols [TOTAL_COLUMNS];
    logic [COLUMN_SIZE-1:0]   w_row_next;

    assign w_frame_ready = !r_pending && !i_attack;
    assign w_accept      = i_frame_valid && w_frame_ready;
    assign w_pre_wrap    = (r_prescaler == PRE_LAST);
    assign w_boundary    = i_enable && w_pre_wrap && (r_col == COL_LAST);
    // With the scan stopped there is no boundary to wait for, so a pending
    // frame is promoted immediately.
    assign w_swap        = r_pending && !i_attack && (w_boundary || !i_enable);

    // Per-column views of the active frame and the one-hot column decode.
    genvar gi;
    generate
        for (gi = 0; gi < TOTAL_COLUMNS; gi++) begin : g_col
            assign w_col_onehot[gi]  = (r_col == COL_W'(gi));
            assign w_active_cols[gi] = r_active[gi*COLUMN_SIZE +: COLUMN_SIZE];
        end
    endgenerate

`ifdef MAP_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0]     r_blink_cnt;
    logic                   r_blink_phase;
    logic [COLUMN_SIZE-1:0] w_mask_cols [TOTAL_COLUMNS];

    generate
        for (gi = 0; gi < TOTAL_COLUMNS; gi++) begin : g_mask
            assign w_mask_cols[gi] = i_blink_mask[gi*COLUMN_SIZE +: COLUMN_SIZE];
        end
    endgenerate

    // Counts on the boundary itself (the cycle before frame_done) so the
    // phase changes exactly when column 0 of the next scan is loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!i_enable) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_boundary) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= !r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Off phase: force masked pixels to 1 (unlit).
    assign w_row_next = w_active_cols[r_col] |
                        (r_blink_phase ? w_mask_cols[r_col] : '0);
`else
    assign w_row_next = w_active_cols[r_col];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow     <= '1;
            r_active     <= '1;
            r_pending    <= 1'b0;
            r_prescaler  <= '0;
            r_col        <= '0;
            r_column_sel <= '1;
            r_row_out    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            // Accept and swap are mutually exclusive: accept needs !pending.
            if (w_accept) begin
                r_shadow  <= i_frame_in;
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end

            if (!i_enable) begin
                r_prescaler <= '0;
                r_col       <= '0;
            end else if (w_pre_wrap) begin
                r_prescaler <= '0;
                r_col       <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            r_column_sel <= i_enable ? ~w_col_onehot : '1;
            r_row_out    <= i_enable ? w_row_next : '1;
            r_frame_done <= w_boundary;
        end
    end

    assign o_frame_ready = w_frame_ready;
    assign o_column_sel  = r_column_sel;
    assign o_row_out     = r_row_out;
    assign o_frame_done  = r_frame_done;

endmodule

// File: doc/map_matrix_scanner.md
# map_matrix_scanner

Parametrised column-multiplexed driver for the game's pixel-matrix display. It sits after the map decoder: it accepts a full active-low frame (COLUMN_SIZE × TOTAL_COLUMNS bits, column-major, 0 = pixel lit) through a valid/ready handshake, double-buffers it, and scans it onto one-hot column-select and row lines. It adds tear-free frame swaps, an attack freeze and an optional blink overlay.

## Interface
- COLUMN_SIZE, 7, pixels per column (row lines)
- TOTAL_COLUMNS, 5, number of columns
- DATA_WIDTH, COLUMN_SIZE*TOTAL_COLUMNS, frame width; bit c*COLUMN_SIZE+r = column c, row r
- SCAN_DIV, 1000, clock cycles each column is driven (≥1)
- BLINK_FRAMES, 16, full scans per blink half-period (MAP_BLINK_EN only)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = scan display; 0 = blank outputs, counters held at 0
- frame_in  in  DATA_WIDTH  new frame, active-low pixels
- frame_valid  in  1  frame_in valid
- frame_ready  out  1  block can accept a frame
- attack  in  1  level; 1 = freeze displayed frame
- blink_mask  in  DATA_WIDTH  1 = pixel blinks (MAP_BLINK_EN only)
- column_sel  out  TOTAL_COLUMNS  active-low one-hot column select
- row_out  out  COLUMN_SIZE  active-low row data of selected column
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Registers: shadow and active frame buffers, pending flag, prescaler (0..SCAN_DIV-1), column index col (0..TOTAL_COLUMNS-1).
- Reset: shadow = active = all ones (blank), pending = 0, prescaler = 0, col = 0, column_sel = all ones, row_out = all ones, frame_done = 0; frame_ready = 1 after release if attack = 0.
- frame_ready = !pending && !attack (combinational). Accept when frame_valid && frame_ready: shadow <= frame_in, pending <= 1. frame_valid with ready low is ignored; source holds it.
- Scan (enable = 1): prescaler increments each cycle; at SCAN_DIV-1 it wraps to 0 and col advances, wrapping TOTAL_COLUMNS-1 → 0. The wrapping cycle from col = TOTAL_COLUMNS-1 is the frame boundary.
- Swap: at the frame boundary, if pending && !attack: active <= shadow, pending <= 0. A new frame therefore always starts on column 0. With enable = 0 the swap happens on any cycle where pending && !attack.
- Attack: while attack = 1, no accepts and no swaps; active frame is held and scanning continues. A pending frame stays in shadow and swaps at the first boundary after attack falls.
- enable = 0: prescaler = col = 0 next cycle; buffers retained.
- frame_done = 1 for the cycle following each frame boundary (registered).

## Timing
- column_sel and row_out are registered: each cycle they take all ones if enable = 0, else ~(1<<col) and active[col*COLUMN_SIZE +: COLUMN_SIZE]. One-cycle latency from col/active change to pins.
- After enable rises, column 0 appears one cycle later and holds for SCAN_DIV cycles.
- Accept → earliest display: the frame boundary following the accept, plus one cycle.
- Accept and swap cannot occur in the same cycle, because ready requires !pending.
- SCAN_DIV = 1: col advances every cycle, frame boundary every TOTAL_COLUMNS cycles.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous).

## Configuration
- MAP_BLINK_EN defined: adds the blink_mask port and a blink counter that counts frame_done pulses. The blink phase toggles every BLINK_FRAMES pulses and resets to 0 (visible). In the off phase, the row bits whose blink_mask bit is 1 are forced to 1 (unlit) before the output register. Blink counter and phase are cleared by reset and when enable = 0.
- MAP_BLINK_EN undefined: no blink_mask port, no counter; row_out is exactly the active frame.

## Test plan
- Reset release, SCAN_DIV = 4, enable = 1, no frame → column_sel cycles 11110, 11101, … 01111, 4 cycles each; row_out = 1111111; frame_done pulses every 20 cycles.
- Load a frame with column 2 = 0000000 mid-scan at col = 1 → frame_ready drops for one boundary; the frame first appears at the next column 0, and row_out = 0000000 only while column_sel = 11011.
- Hold attack = 1, offer a second frame → frame_ready = 0 and frame unchanged for ≥3 scans; drop attack, offer frame → swap at the next boundary.
- Load frame A then, while pending, keep frame_valid high with frame B → B accepted only in the cycle after the A swap; no frame lost or torn.
- enable = 0 mid-column → next cycle column_sel = 11111, row_out = 1111111; pending frame swaps within 1 cycle; re-enable → column 0 after 1 cycle.
- MAP_BLINK_EN, BLINK_FRAMES = 2, blink_mask bit 0 = 1, frame all lit → row_out[0] of column 0 alternates lit/unlit every 2 frames; other bits steady 0.
